dsp_mac_sched: RTL and testbench
================================

DSP_MAC_SCHED -- requirements
Module: dsp_mac_sched

Interface
REQ-001 Parameter LEN_W, default 8, SHALL set the width of the burst-length inputs.
REQ-002 Parameter PIPE_DEPTH, default 3, legal 1..4, SHALL equal the register count from operand input to the P register of the shared slice.
REQ-003 Port CLK  in  1  SHALL be the single clock; all state updates on the falling edge.
REQ-004 Port RST  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 Port req  in  2  SHALL carry per-requester burst requests, bit i = requester i.
REQ-006 Ports len0, len1  in  LEN_W  SHALL give the number of MAC operations per burst, sampled at grant.
REQ-007 Port gnt  out  2  SHALL be one-hot (or zero), marking the current slice owner.
REQ-008 Port op_strobe  out  1  SHALL tell the owner its operands are consumed this cycle.
REQ-009 Ports ce_in, ce_m, ce_p  out  1 each  SHALL drive the slice input, multiplier and P register clock enables.
REQ-010 Port opm_acc  out  1  SHALL select P-stage operation: 0 = P<=M, 1 = P<=P+M.
REQ-011 Port busy  out  1  SHALL be high whenever the FSM is not IDLE.
REQ-012 Ports res_valid  out  1, res_owner  out  1  SHALL flag the final accumulated result and its requester index.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE.
REQ-014 IDLE: a requester is eligible only when req[i]=1 and len_i!=0; zero-length requests are never granted.
REQ-015 Arbitration SHALL be round-robin: a priority pointer selects the requester that did not own the most recently completed burst; after reset the pointer favours requester 0.
REQ-016 On an edge in IDLE with at least one eligible requester: gnt set, len latched into an op counter, transition to ISSUE.
REQ-017 ISSUE SHALL last exactly len cycles, with op_strobe=1, ce_in=ce_m=ce_p=1 in each cycle.
REQ-018 After the last ISSUE cycle, the FSM SHALL enter DRAIN for exactly PIPE_DEPTH cycles, with op_strobe=0, ce_in=ce_m=ce_p=1.
REQ-019 DONE SHALL last one cycle: res_valid=1, res_owner=granted index, all CEs 0; next state IDLE; pointer updated.
REQ-020 opm_acc SHALL be a copy of a per-operation "not first" flag delayed by PIPE_DEPTH-1 cycles, so it is 0 exactly when the first product of the burst enters P and 1 for each later product.
REQ-021 gnt SHALL stay constant from ISSUE entry through DONE; req deassertion mid-burst SHALL NOT shorten the burst; len changes after grant SHALL be ignored.
REQ-022 Total burst occupancy SHALL be len + PIPE_DEPTH + 1 cycles from ISSUE entry to return to IDLE; the next grant is issued on the edge leaving IDLE, giving one idle cycle between bursts.
REQ-023 In IDLE, all CEs, op_strobe, opm_acc and res_valid SHALL be 0.

Reset
REQ-024 RST=1 SHALL immediately force state IDLE, gnt=0, op_strobe=0, all CEs 0, opm_acc=0, busy=0, res_valid=0, res_owner=0, counters 0, pointer to requester 0, regardless of the state it interrupts.
REQ-025 After RST deasserts, the first grant SHALL occur no earlier than the first falling edge with RST low.

Verification
REQ-026 req=01, len0=4, PIPE_DEPTH=3 -> gnt=01; op_strobe high 4 cycles; CEs high 7 cycles; opm_acc 0 then 1,1,1 starting on the 3rd ISSUE cycle; res_valid=1, res_owner=0 in cycle 8.
REQ-027 req=11 held, len0=len1=2 -> grants alternate 01,10,01 with one IDLE cycle between bursts; res_owner alternates 0,1,0.
REQ-028 req=10, len1=0, then len1=5 -> no grant while 0; burst of 5 once nonzero.
REQ-029 Assert RST during DRAIN of a 6-op burst -> all outputs 0 within the same cycle; after release with req=11, requester 0 is granted first.
REQ-030 req0 dropped in the 2nd ISSUE cycle of a len0=3 burst; len0 changed to 9 -> burst still runs 3 ops and completes with res_owner=0.
REQ-031 PIPE_DEPTH=1, len=1 -> opm_acc=0 in the single ISSUE cycle; DRAIN 1 cycle; res_valid in cycle 3.

Source files
------------

// File: rtl/dsp_mac_sched.sv
// ---------------------------------------------------------------------------
// dsp_mac_sched
//   Schedules bursts of multiply-accumulate operations from two requesters
//   onto one shared multiplier slice (input reg -> M reg -> P reg). A round-
//   robin arbiter grants the slice for one burst at a time. It then drives the
//   slice clock enables and the P-stage opcode so that each burst accumulates
//   into P from a clean start.
//   All state changes on the falling edge of CLK.
//
// Ports
//   CLK, RST          clock (falling-edge active), async active-high reset
//   req[1:0]          burst request per requester
//   len0, len1        MAC count per burst, sampled when the grant is issued
//   gnt[1:0]          one-hot slice owner, zero when idle
//   op_strobe         owner's operands are consumed this cycle
//   ce_in, ce_m, ce_p clock enables for slice input, multiplier and P regs
//   opm_acc           P-stage op: 0 = P<=M, 1 = P<=P+M
//   busy              scheduler is not idle
//   res_valid         final accumulated result is in P this cycle
//   res_owner         requester index that owns the result in res_valid
// ---------------------------------------------------------------------------
module dsp_mac_sched #(
    parameter int LEN_W      = 8,
    parameter int PIPE_DEPTH = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       gnt,
    output logic             op_strobe,
    output logic             ce_in,
    output logic             ce_m,
    output logic             ce_p,
    output logic             opm_acc,
    output logic             busy,
    output logic             res_valid,
    output logic             res_owner
);

    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
        $error("dsp_mac_sched: PIPE_DEPTH must be in 1..4");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state;
    logic [LEN_W-1:0] cnt;       // remaining cycles in the current ISSUE/DRAIN phase, minus one
    logic             owner;     // granted requester index
    logic             ptr;       // preferred requester when both are eligible
    logic [2:0]       nf_p;      // not-first flag history: [0] = current cycle, [j] = j cycles ago

    logic [1:0]       elig;
    logic             win;
    logic [LEN_W-1:0] win_len;
    logic             nf_next;
    logic             opm_next;

    always_comb begin
        elig    = {req[1] && (len1 != '0), req[0] && (len0 != '0)};
        win     = (elig == 2'b11) ? ptr : elig[1];
        win_len = win ? len1 : len0;
        // Next cycle carries a non-first operation of the burst.
        nf_next = (state == ISSUE) && (cnt != '0);
        // The opcode for a product must arrive with it at P, PIPE_DEPTH-1
        // cycles after its operands were consumed.
        opm_next = nf_next;
        for (int j = 0; j < 3; j++) begin
            if (j == PIPE_DEPTH - 2) opm_next = nf_p[j];
        end
    end

    // Falling-edge stage: FSM, counters and registered outputs
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= 1'b0;
            ptr       <= 1'b0;
            nf_p      <= '0;
            gnt       <= 2'b00;
            op_strobe <= 1'b0;
            ce_in     <= 1'b0;
            ce_m      <= 1'b0;
            ce_p      <= 1'b0;
            opm_acc   <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_owner <= 1'b0;
        end else begin
            nf_p    <= {nf_p[1:0], nf_next};
            opm_acc <= opm_next;
            case (state)
                IDLE: begin
                    if (elig != 2'b00) begin
                        state     <= ISSUE;
                        owner     <= win;
                        gnt       <= win ? 2'b10 : 2'b01;
                        cnt       <= win_len - 1'b1;
                        op_strobe <= 1'b1;
                        ce_in     <= 1'b1;
                        ce_m      <= 1'b1;
                        ce_p      <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (cnt == '0) begin
                        state     <= DRAIN;
                        cnt       <= LEN_W'(PIPE_DEPTH - 1);
                        op_strobe <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        state     <= DONE;
                        ce_in     <= 1'b0;
                        ce_m      <= 1'b0;
                        ce_p      <= 1'b0;
                        res_valid <= 1'b1;
                        res_owner <= owner;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    gnt       <= 2'b00;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                    res_owner <= 1'b0;
                    // The requester that just finished loses priority.
                    ptr       <= ~owner;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mac_sched.sv
module tb_dsp_mac_sched;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] req = 2'b00;
    logic [7:0] len0 = 8'd0;
    logic [7:0] len1 = 8'd0;

    logic [1:0] gnt, gnt_b;
    logic op_strobe, ce_in, ce_m, ce_p, opm_acc, busy, res_valid, res_owner;
    logic op_strobe_b, ce_in_b, ce_m_b, ce_p_b, opm_acc_b, busy_b, res_valid_b, res_owner_b;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    dsp_mac_sched #(.LEN_W(8), .PIPE_DEPTH(3)) dut (
        .CLK(CLK), .RST(RST), .req(req), .len0(len0), .len1(len1),
        .gnt(gnt), .op_strobe(op_strobe), .ce_in(ce_in), .ce_m(ce_m), .ce_p(ce_p),
        .opm_acc(opm_acc), .busy(busy), .res_valid(res_valid), .res_owner(res_owner)
    );

    dsp_mac_sched #(.LEN_W(8), .PIPE_DEPTH(1)) dut1 (
        .CLK(CLK), .RST(RST), .req(req), .len0(len0), .len1(len1),
        .gnt(gnt_b), .op_strobe(op_strobe_b), .ce_in(ce_in_b), .ce_m(ce_m_b), .ce_p(ce_p_b),
        .opm_acc(opm_acc_b), .busy(busy_b), .res_valid(res_valid_b), .res_owner(res_owner_b)
    );

    // {gnt, op_strobe, ce_in, ce_m, ce_p, opm_acc, busy, res_valid, res_owner}
    logic [9:0] obs_a, obs_b;
    assign obs_a = {gnt, op_strobe, ce_in, ce_m, ce_p, opm_acc, busy, res_valid, res_owner};
    assign obs_b = {gnt_b, op_strobe_b, ce_in_b, ce_m_b, ce_p_b, opm_acc_b, busy_b, res_valid_b, res_owner_b};

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [7:0] l0;
        logic [7:0] l1;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[32];
    int   ntbl = 0;

    function automatic logic [9:0] mk(input logic [1:0] g, input logic s, input logic c,
                                      input logic o, input logic b, input logic rv, input logic ro);
        return {g, s, c, c, c, o, b, rv, ro};
    endfunction

    task automatic add(input logic r, input logic [1:0] rq, input logic [7:0] a, input logic [7:0] b,
                       input logic [9:0] e);
        tbl[ntbl] = '{rst: r, req: rq, l0: a, l1: b, exp: e};
        ntbl++;
    endtask

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        @(posedge CLK);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            if (!busy && !busy_b) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_wait", {9'd0, ok}, 10'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] eg;
        logic       es, erv, ero;
        int         b, p, strobes, busy_cnt, rv_cnt, gnt_bad;
        logic       ro_seen;

        // ---- table: reset, len0=4 burst, zero-length then len1=5 burst ----
        add(1, 2'b00, 8'd0, 8'd0, mk(2'b00, 0, 0, 0, 0, 0, 0));
        add(0, 2'b01, 8'd4, 8'd0, mk(2'b01, 1, 1, 0, 1, 0, 0));
        add(0, 2'b00, 8'd4, 8'd0, mk(2'b01, 1, 1, 0, 1, 0, 0));
        add(0, 2'b00, 8'd4, 8'd0, mk(2'b01, 1, 1, 0, 1, 0, 0));
        add(0, 2'b00, 8'd4, 8'd0, mk(2'b01, 1, 1, 1, 1, 0, 0));
        add(0, 2'b00, 8'd4, 8'd0, mk(2'b01, 0, 1, 1, 1, 0, 0));
        add(0, 2'b00, 8'd4, 8'd0, mk(2'b01, 0, 1, 1, 1, 0, 0));
        add(0, 2'b00, 8'd4, 8'd0, mk(2'b01, 0, 1, 0, 1, 0, 0));
        add(0, 2'b00, 8'd4, 8'd0, mk(2'b01, 0, 0, 0, 1, 1, 0));
        add(0, 2'b00, 8'd4, 8'd0, mk(2'b00, 0, 0, 0, 0, 0, 0));
        add(0, 2'b10, 8'd0, 8'd0, mk(2'b00, 0, 0, 0, 0, 0, 0));
        add(0, 2'b10, 8'd0, 8'd0, mk(2'b00, 0, 0, 0, 0, 0, 0));
        add(0, 2'b10, 8'd0, 8'd5, mk(2'b10, 1, 1, 0, 1, 0, 0));
        add(0, 2'b00, 8'd0, 8'd0, mk(2'b10, 1, 1, 0, 1, 0, 0));
        add(0, 2'b00, 8'd0, 8'd0, mk(2'b10, 1, 1, 0, 1, 0, 0));
        add(0, 2'b00, 8'd0, 8'd0, mk(2'b10, 1, 1, 1, 1, 0, 0));
        add(0, 2'b00, 8'd0, 8'd0, mk(2'b10, 1, 1, 1, 1, 0, 0));
        add(0, 2'b00, 8'd0, 8'd0, mk(2'b10, 0, 1, 1, 1, 0, 0));
        add(0, 2'b00, 8'd0, 8'd0, mk(2'b10, 0, 1, 1, 1, 0, 0));
        add(0, 2'b00, 8'd0, 8'd0, mk(2'b10, 0, 1, 0, 1, 0, 0));
        add(0, 2'b00, 8'd0, 8'd0, mk(2'b10, 0, 0, 0, 1, 1, 1));
        add(0, 2'b00, 8'd0, 8'd0, mk(2'b00, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < ntbl; i++) begin
            RST  = tbl[i].rst;
            req  = tbl[i].req;
            len0 = tbl[i].l0;
            len1 = tbl[i].l1;
            cyc();
            chk($sformatf("vec%0d", i), obs_a, tbl[i].exp);
        end

        // ---- round robin with both requesting, len=2 each ----
        req = 2'b11; len0 = 8'd2; len1 = 8'd2;
        for (int c = 0; c < 20; c++) begin
            cyc();
            b   = c / 7;
            p   = c % 7;
            eg  = (p == 6) ? 2'b00 : ((b % 2 == 1) ? 2'b10 : 2'b01);
            es  = (p < 2);
            erv = (p == 5);
            ero = erv && (b % 2 == 1);
            chk($sformatf("rr_c%0d", c), {5'd0, gnt, op_strobe, res_valid, res_owner},
                {5'd0, eg, es, erv, ero});
            if (c == 19) req = 2'b00;
        end
        wait_idle();

        // ---- async reset during DRAIN of a 6-op burst ----
        req = 2'b01; len0 = 8'd6; len1 = 8'd0;
        cyc();
        chk("rst_burst_c1", obs_a, mk(2'b01, 1, 1, 0, 1, 0, 0));
        req = 2'b00;
        repeat (6) cyc();
        chk("rst_in_drain", {7'd0, op_strobe, ce_p, busy}, 10'b011);
        RST = 1'b1;
        #1;
        chk("rst_async_a", obs_a, 10'd0);
        chk("rst_async_b", obs_b, 10'd0);
        @(posedge CLK);
        RST = 1'b0; req = 2'b11; len0 = 8'd2; len1 = 8'd2;
        cyc();
        chk("rst_first_gnt", obs_a, mk(2'b01, 1, 1, 0, 1, 0, 0));
        req = 2'b00;
        wait_idle();

        // ---- req drop and len change mid-burst ----
        req = 2'b01; len0 = 8'd3; len1 = 8'd0;
        strobes = 0; busy_cnt = 0; rv_cnt = 0; gnt_bad = 0; ro_seen = 1'b1;
        for (int c = 0; c < 30; c++) begin
            cyc();
            if (!busy) break;
            busy_cnt++;
            if (op_strobe) strobes++;
            if (gnt != 2'b01) gnt_bad++;
            if (res_valid) begin
                rv_cnt++;
                ro_seen = res_owner;
            end
            if (c == 1) begin
                req  = 2'b00;
                len0 = 8'd9;
            end
        end
        chk("drop_strobes", 10'(strobes), 10'd3);
        chk("drop_busy_cycles", 10'(busy_cnt), 10'd7);
        chk("drop_res_valid", 10'(rv_cnt), 10'd1);
        chk("drop_res_owner", {9'd0, ro_seen}, 10'd0);
        chk("drop_gnt_stable", 10'(gnt_bad), 10'd0);
        wait_idle();

        // ---- PIPE_DEPTH=1, single op ----
        req = 2'b01; len0 = 8'd1;
        cyc();
        chk("d1_issue", obs_b, mk(2'b01, 1, 1, 0, 1, 0, 0));
        req = 2'b00;
        cyc();
        chk("d1_drain", obs_b, mk(2'b01, 0, 1, 0, 1, 0, 0));
        cyc();
        chk("d1_done", obs_b, mk(2'b01, 0, 0, 0, 1, 1, 0));
        cyc();
        chk("d1_idle", obs_b, 10'd0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
